// File: rtl/serial_bus_responder.sv
// serial_bus_responder: 6502-bus UART peripheral for the $9F60-$9F6F window.
// A byte-wide register file, an 8N1 transmitter fed by a small FIFO, a receiver
// with a single holding register and an active-low interrupt output.
module serial_bus_responder #(
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd68
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  logic       srlEn,
    input  logic       rw,
    input  logic [3:0] adr,
    input  logic [7:0] datIn,
    output logic [7:0] datOut,
    output logic       datOe,
    output logic       irqN,
    input  logic       rxd,
    output logic       txd
);
    localparam int unsigned AW     = $clog2(TX_DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus decode ----------------
    logic        r_phi2_q;
    logic        w_commit, w_wr, w_rd;
    logic        w_wr_data, w_rd_data, w_rd_status, w_soft_rst;
    logic [15:0] r_div;
    logic [1:0]  r_ctrl;

    // phi2 delayed one clk so its falling edge marks the single commit point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phi2_q <= 1'b0;
        else     r_phi2_q <= phi2;
    end

    assign w_commit    = r_phi2_q & ~phi2 & ~srlEn;
    assign w_wr        = w_commit & ~rw;
    assign w_rd        = w_commit & rw;
    assign w_wr_data   = w_wr & (adr == 4'd0);
    assign w_rd_data   = w_rd & (adr == 4'd0);
    assign w_rd_status = w_rd & (adr == 4'd1);
    assign w_soft_rst  = w_wr & (adr == 4'd4) & datIn[7];

    // Divisor and control registers. A CTRL write with bit7 set is a pure
    // soft-reset command and leaves the interrupt enables untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= DIV_RESET;
            r_ctrl <= 2'b00;
        end else if (w_wr) begin
            case (adr)
                4'd2:    r_div[7:0]  <= datIn;
                4'd3:    r_div[15:8] <= datIn;
                4'd4:    if (!datIn[7]) r_ctrl <= datIn[1:0];
                default: ;
            endcase
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  r_fifo [TX_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_tx_full, w_tx_empty, w_push, w_tx_pop;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_tx_full  = (w_count == L_FULL);
    assign w_tx_empty = (r_wr_ptr == r_rd_ptr);
    // fullness is judged before any same-cycle pop
    assign w_push     = w_wr_data & ~w_tx_full;

    // FIFO storage; the head is captured into the TX shift register on pop
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= datIn;
    end

    // FIFO pointers; soft reset discards everything not yet popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_soft_rst) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_tx_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    state_t      r_tx_state, w_tx_state_next;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        w_tx_tick, w_tx_busy;

    assign w_tx_tick = (r_tx_cnt == 16'd0);
    assign w_tx_pop  = (r_tx_state == S_IDLE) & ~w_tx_empty;
    assign w_tx_busy = (r_tx_state != S_IDLE);

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= S_IDLE;
        else     r_tx_state <= w_tx_state_next;
    end

    // TX next-state: every non-idle state lasts one bit period
    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (!w_tx_empty) w_tx_state_next = S_START;
            S_START: if (w_tx_tick) w_tx_state_next = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_state_next = S_STOP;
            S_STOP:  if (w_tx_tick) w_tx_state_next = S_IDLE;
            default: w_tx_state_next = S_IDLE;
        endcase
    end

    // TX datapath: divisor is latched at pop so a mid-frame DIV write waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
        end else if (r_tx_state == S_IDLE) begin
            if (w_tx_pop) begin
                r_tx_shift <= r_fifo[r_rd_ptr[AW-1:0]];
                r_tx_cnt   <= r_div;
                r_tx_div   <= r_div;
                r_tx_bit   <= 3'd0;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt <= r_tx_div;
            if (r_tx_state == S_DATA) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
        end
    end

    // TX output: line level from state, so async reset returns it high at once
    always_comb begin
        txd = 1'b1;
        case (r_tx_state)
            S_START: txd = 1'b0;
            S_DATA:  txd = r_tx_shift[0];
            default: txd = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    state_t      r_rx_state, w_rx_state_next;
    logic [15:0] r_rx_cnt, r_rx_div, w_rx_half;
    logic [7:0]  r_rx_shift, r_rx_hold;
    logic [2:0]  r_rx_bit;
    logic        r_rx_valid, r_overrun;
    logic        w_rx_fall, w_rx_tick, w_rx_stop_ok;

    // two-flop synchronizer plus one more stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
    assign w_rx_tick = (r_rx_cnt == 16'd0);
    // half a bit period; zero means the edge sample itself is mid-bit
    assign w_rx_half = 16'(({1'b0, r_div} + 17'd1) >> 1);

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= S_IDLE;
        else     r_rx_state <= w_rx_state_next;
    end

    // RX next-state: re-check start bit at mid-bit, glitches fall back to idle
    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_state_next = (w_rx_half == 16'd0) ? S_DATA : S_START;
            S_START: if (w_rx_tick) w_rx_state_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_next = S_STOP;
            S_STOP:  if (w_rx_tick) w_rx_state_next = S_IDLE;
            default: w_rx_state_next = S_IDLE;
        endcase
    end

    // RX datapath: counter runs from the edge to each mid-bit sample point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else if (r_rx_state == S_IDLE) begin
            if (w_rx_fall) begin
                r_rx_div <= r_div;
                r_rx_cnt <= (w_rx_half == 16'd0) ? r_div : (w_rx_half - 16'd1);
                r_rx_bit <= 3'd0;
            end
        end else if (w_rx_tick) begin
            r_rx_cnt <= r_rx_div;
            if (r_rx_state == S_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
        end
    end

    // RX output: a good stop bit delivers the byte
    assign w_rx_stop_ok = (r_rx_state == S_STOP) & w_rx_tick & r_rx_s2;

    // Holding register and flags; a same-cycle DATA read frees the slot so the
    // new byte loads and rxValid stays set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_hold  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_soft_rst) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_rx_stop_ok && (!r_rx_valid || w_rd_data)) begin
                r_rx_hold  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_stop_ok && r_rx_valid && !w_rd_data) r_overrun <= 1'b1;
            else if (w_rd_status)                         r_overrun <= 1'b0;
        end
    end

    // ---------------- read path and IRQ ----------------
    logic [7:0] w_rd_mux;
    logic       r_irq_n;

    // register read mux, gated to zero while the chip is not selected
    always_comb begin
        w_rd_mux = 8'h00;
        case (adr)
            4'd0:    w_rd_mux = r_rx_hold;
            4'd1:    w_rd_mux = {3'b000, w_tx_busy, r_overrun, w_tx_empty, w_tx_full, r_rx_valid};
            4'd2:    w_rd_mux = r_div[7:0];
            4'd3:    w_rd_mux = r_div[15:8];
            4'd4:    w_rd_mux = {6'b000000, r_ctrl};
            default: w_rd_mux = 8'h00;
        endcase
    end

    assign datOut = srlEn ? 8'h00 : w_rd_mux;
    assign datOe  = ~srlEn & rw & phi2;

    // registered interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_irq_n <= 1'b1;
        else     r_irq_n <= ~((r_ctrl[0] & r_rx_valid) |
                              (r_ctrl[1] & w_tx_empty & ~w_tx_busy));
    end

    assign irqN = r_irq_n;

endmodule
